// File: rtl/range_repack_stage_if.sv
// Handshake bundle for range_repack_stage: descending-range input bus, ascending-range output bus
// and the accepted-word counter.
interface range_repack_stage_if #(
  parameter int          MSB   = 2,
  parameter int          LSB   = -2,
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [MSB:LSB]   in_data;
  logic             in_swap;
  logic             out_valid;
  logic             out_ready;
  logic [LSB:MSB]   out_data;
  logic [CNT_W-1:0] xfer_cnt;

  // Producer/consumer side that drives the stage.
  modport master (
    output in_valid, in_data, in_swap, out_ready,
    input  in_ready, out_valid, out_data, xfer_cnt
  );

  // The stage itself.
  modport slave (
    input  in_valid, in_data, in_swap, out_ready,
    output in_ready, out_valid, out_data, xfer_cnt
  );
endinterface

// File: rtl/range_repack_stage.sv
// Two-entry elastic stage that repacks descending [MSB:LSB] words onto an ascending [LSB:MSB]
// bus, with an optional per-word swap of the high [MSB:SPLIT] and low [SPLIT-1:LSB] slices.
module range_repack_stage #(
  parameter int          MSB   = 2,
  parameter int          LSB   = -2,
  parameter int          SPLIT = 0,
  parameter int unsigned CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  range_repack_stage_if.slave   bus
);
  // W must be >= 2 and LSB < SPLIT <= MSB so both slices are non-empty.
  localparam int W = MSB - LSB + 1;

  typedef enum logic [1:0] {StEmpty, StOne, StFull} occ_e;

  occ_e             occ_q, occ_d;
  logic [W-1:0]     head_q, head_d;
  logic [W-1:0]     skid_q, skid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     w;
  logic             accept;
  logic             pop;

  always_comb begin
    if (bus.in_swap) begin
      w = {bus.in_data[SPLIT-1:LSB], bus.in_data[MSB:SPLIT]};
    end else begin
      w = bus.in_data;
    end
  end

  assign bus.in_ready  = (occ_q != StFull) && !rst;
  assign bus.out_valid = (occ_q != StEmpty);
  // Positional copy: head_q[W-1] (leftmost bit of w) lands on out_data[LSB].
  assign bus.out_data  = head_q;
  assign bus.xfer_cnt  = cnt_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign pop    = bus.out_valid && bus.out_ready;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    skid_d = skid_q;
    cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, accept};
    unique case (occ_q)
      StEmpty: begin
        if (accept) begin
          head_d = w;
          occ_d  = StOne;
        end
      end
      StOne: begin
        if (accept && pop) begin
          head_d = w;
        end else if (accept) begin
          skid_d = w;
          occ_d  = StFull;
        end else if (pop) begin
          occ_d  = StEmpty;
        end
      end
      StFull: begin
        if (pop) begin
          head_d = skid_q;
          occ_d  = StOne;
        end
      end
      default: occ_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q  <= StEmpty;
      head_q <= '0;
      skid_q <= '0;
      cnt_q  <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      skid_q <= skid_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule
